tsn_eos_sched: RTL and testbench

//  Parametrised egress output scheduler for the UM TSN pipeline; successor to the fixed 4-queue eos.

---
 rtl/tsn_eos_sched.sv | 210 +++++++++++++++++++++
 tb/tb_tsn_eos_sched.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tsn_eos_sched.sv
// -----------------------------------------------------------------------------
// tsn_eos_sched -- egress output scheduler for the UM TSN pipeline.
//
// Holds packet metadata (buffer ID, length) from ibm in NQ per-queue FIFOs and
// releases one word at a time to ebm. Queue 0 has the highest priority. Each
// queue has a time-slot gate. The last queue (NQ-1) is also limited by a
// token-bucket shaper. Metadata refused on overflow goes out on the discard
// channel so that data_cache can free the buffer.
//
// Build option:
//   EOS_DROP_OLDEST_EN  When defined, overflow evicts the head (oldest) entry
//                       and appends the new one. The evicted ID is reported.
//                       When undefined, the incoming metadata is tail-dropped.
//
// Ports:
//   clk, rst_n           clock and synchronous active-low reset
//   in_md_wr/queue/id/len  metadata write, 1 cycle per packet
//   in_gate_mask         bit q=1: the gate of queue q is open
//   cfg_rate             tokens (bytes) added per cycle; 0 disables the shaper
//   cfg_bucket           token bucket ceiling
//   out_ready            ebm can accept metadata (level)
//   in_tx_done           ebm has sent the tail of the issued packet (pulse)
//   out_md_wr/queue/id/len  issued metadata, registered, 1-cycle strobe
//   out_drop_wr/id       discard strobe and the buffer ID to free
//   out_used_cnt         per-queue occupancy; queue q in bits [q*CW +: CW]
//   out_mdin_cnt, out_mdout_cnt, out_drop_cnt  wrapping event counters
// -----------------------------------------------------------------------------
module tsn_eos_sched #(
  parameter int NQ      = 4,
  parameter int DEPTH   = 16,
  parameter int ID_W    = 8,
  parameter int LEN_W   = 12,
  parameter int TOKEN_W = 16,
  localparam int QW = (NQ > 1) ? $clog2(NQ) : 1,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_md_wr,
  input  logic [QW-1:0]      in_md_queue,
  input  logic [ID_W-1:0]    in_md_id,
  input  logic [LEN_W-1:0]   in_md_len,
  input  logic [NQ-1:0]      in_gate_mask,
  input  logic [TOKEN_W-1:0] cfg_rate,
  input  logic [TOKEN_W-1:0] cfg_bucket,
  input  logic               out_ready,
  input  logic               in_tx_done,
  output logic               out_md_wr,
  output logic [QW-1:0]      out_md_queue,
  output logic [ID_W-1:0]    out_md_id,
  output logic [LEN_W-1:0]   out_md_len,
  output logic               out_drop_wr,
  output logic [ID_W-1:0]    out_drop_id,
  output logic [NQ*CW-1:0]   out_used_cnt,
  output logic [63:0]        out_mdin_cnt,
  output logic [63:0]        out_mdout_cnt,
  output logic [31:0]        out_drop_cnt
);

  localparam int MD_W = ID_W + LEN_W;
  // Wide enough for tokens + rate without overflow, and for comparing
  // tokens with a packet length.
  localparam int XW = ((TOKEN_W > LEN_W) ? TOKEN_W : LEN_W) + 1;

`ifdef EOS_DROP_OLDEST_EN
  localparam bit DROP_OLDEST = 1'b1;
`else
  localparam bit DROP_OLDEST = 1'b0;
`endif

  typedef enum logic {IDLE, WAIT_DONE} state_t;
  state_t state;

  logic [MD_W-1:0]    mem    [NQ][DEPTH];
  logic [AW-1:0]      rd_ptr [NQ];
  logic [AW-1:0]      wr_ptr [NQ];
  logic [CW-1:0]      cnt    [NQ];
  logic [TOKEN_W-1:0] tokens;

  logic [ID_W-1:0]  head_id  [NQ];
  logic [LEN_W-1:0] head_len [NQ];
  logic [NQ-1:0]    elig, wr_hit, full;
  logic [NQ-1:0]    pop_vec, acc_vec, ovf_vec, evict_vec, app_vec;
  logic             any_elig, do_pop;
  logic [QW-1:0]    pop_q;
  logic [ID_W-1:0]  pop_id, ovf_id;
  logic [LEN_W-1:0] pop_len;
  logic [XW-1:0]    tok_sum, tok_sub, tok_dif;
  logic [TOKEN_W-1:0] tok_next;

  // Per-queue head and eligibility. A queue index >= NQ matches no queue,
  // so such a write is ignored.
  always_comb begin
    for (int q = 0; q < NQ; q++) begin
      {head_id[q], head_len[q]} = mem[q][rd_ptr[q]];
      full[q]   = (cnt[q] == CW'(DEPTH));
      wr_hit[q] = in_md_wr && (in_md_queue == QW'(q));
      elig[q]   = (cnt[q] != '0) && in_gate_mask[q] &&
                  ((q != NQ-1) || (cfg_rate == '0) ||
                   (XW'(tokens) >= XW'(head_len[q])));
    end
  end

  // Strict priority: the downward scan leaves the lowest eligible index.
  // NOTE: combinational logic uses blocking '=' and assigns every output a
  // default first, so no path can leave a value held (no latch).
  always_comb begin
    any_elig  = 1'b0;
    pop_q     = '0;
    pop_id    = '0;
    pop_len   = '0;
    ovf_id    = in_md_id;
    pop_vec   = '0;
    acc_vec   = '0;
    ovf_vec   = '0;
    evict_vec = '0;
    app_vec   = '0;
    for (int q = NQ-1; q >= 0; q--) begin
      if (elig[q]) begin
        any_elig = 1'b1;
        pop_q    = QW'(q);
        pop_id   = head_id[q];
        pop_len  = head_len[q];
      end
    end
    do_pop = (state == IDLE) && out_ready && any_elig;
    for (int q = 0; q < NQ; q++) begin
      pop_vec[q]   = do_pop && (pop_q == QW'(q));
      // A full queue that pops in the same cycle still has room.
      acc_vec[q]   = wr_hit[q] && (!full[q] || pop_vec[q]);
      ovf_vec[q]   = wr_hit[q] && full[q] && !pop_vec[q];
      evict_vec[q] = ovf_vec[q] && DROP_OLDEST;
      app_vec[q]   = acc_vec[q] || evict_vec[q];
      if (evict_vec[q]) ovf_id = head_id[q];
    end
  end

  // Token bucket: add and subtract together, clamp at 0, then cap at the ceiling.
  always_comb begin
    tok_sum  = XW'(tokens) + XW'(cfg_rate);
    tok_sub  = pop_vec[NQ-1] ? XW'(head_len[NQ-1]) : '0;
    tok_dif  = (tok_sum > tok_sub) ? (tok_sum - tok_sub) : '0;
    tok_next = (tok_dif > XW'(cfg_bucket)) ? cfg_bucket : tok_dif[TOKEN_W-1:0];
  end

  // NOTE: FIFO storage has no reset. Pointers and counts are reset, so stale
  // contents are never read, and the array can map to plain RAM.
  always_ff @(posedge clk) begin
    for (int q = 0; q < NQ; q++)
      if (app_vec[q]) mem[q][wr_ptr[q]] <= {in_md_id, in_md_len};
  end

  // NOTE: sequential state uses non-blocking '<=' only, so every register
  // samples values from before the edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      tokens        <= '0;
      for (int q = 0; q < NQ; q++) begin
        rd_ptr[q] <= '0;
        wr_ptr[q] <= '0;
        cnt[q]    <= '0;
      end
      out_md_wr     <= 1'b0;
      out_md_queue  <= '0;
      out_md_id     <= '0;
      out_md_len    <= '0;
      out_drop_wr   <= 1'b0;
      out_drop_id   <= '0;
      out_mdin_cnt  <= '0;
      out_mdout_cnt <= '0;
      out_drop_cnt  <= '0;
    end else begin
      tokens <= tok_next;
      for (int q = 0; q < NQ; q++) begin
        if (pop_vec[q] || evict_vec[q]) rd_ptr[q] <= rd_ptr[q] + 1'b1;
        if (app_vec[q])                 wr_ptr[q] <= wr_ptr[q] + 1'b1;
        // An eviction replaces one entry with another, so the count is unchanged.
        cnt[q] <= cnt[q] + CW'(acc_vec[q]) - CW'(pop_vec[q]);
      end

      out_md_wr <= do_pop;
      if (do_pop) begin
        out_md_queue <= pop_q;
        out_md_id    <= pop_id;
        out_md_len   <= pop_len;
      end

      unique case (state)
        IDLE:      if (do_pop)     state <= WAIT_DONE;
        WAIT_DONE: if (in_tx_done) state <= IDLE;
        default:                   state <= IDLE;
      endcase

      out_drop_wr <= |ovf_vec;
      if (|ovf_vec) out_drop_id <= ovf_id;

      out_mdin_cnt  <= out_mdin_cnt  + 64'(|app_vec);
      out_mdout_cnt <= out_mdout_cnt + 64'(do_pop);
      out_drop_cnt  <= out_drop_cnt  + 32'(|ovf_vec);
    end
  end

  always_comb begin
    out_used_cnt = '0;
    for (int q = 0; q < NQ; q++) out_used_cnt[q*CW +: CW] = cnt[q];
  end

endmodule

// File: tb/tb_tsn_eos_sched.sv
// -----------------------------------------------------------------------------
// tb_tsn_eos_sched -- directed self-checking bench for tsn_eos_sched with the
// default parameters (NQ=4, DEPTH=16, ID_W=8, LEN_W=12, TOKEN_W=16).
// Inputs change 1 time unit after the rising edge and outputs are sampled at
// the same point. "Cycle c" is the interval after one rising edge.
// -----------------------------------------------------------------------------
module tb_tsn_eos_sched;
  localparam int CW = 5;

`ifdef EOS_DROP_OLDEST_EN
  localparam logic [7:0] EXP_DROP_ID = 8'h10;  // evicted head
  localparam logic [7:0] EXP_HEAD_ID = 8'h11;  // head after the eviction
`else
  localparam logic [7:0] EXP_DROP_ID = 8'h2A;  // refused incoming md
  localparam logic [7:0] EXP_HEAD_ID = 8'h10;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_md_wr;
  logic [1:0]  in_md_queue;
  logic [7:0]  in_md_id;
  logic [11:0] in_md_len;
  logic [3:0]  in_gate_mask;
  logic [15:0] cfg_rate, cfg_bucket;
  logic        out_ready, in_tx_done;
  logic        out_md_wr;
  logic [1:0]  out_md_queue;
  logic [7:0]  out_md_id;
  logic [11:0] out_md_len;
  logic        out_drop_wr;
  logic [7:0]  out_drop_id;
  logic [19:0] out_used_cnt;
  logic [63:0] out_mdin_cnt, out_mdout_cnt;
  logic [31:0] out_drop_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tsn_eos_sched dut (
    .clk(clk), .rst_n(rst_n),
    .in_md_wr(in_md_wr), .in_md_queue(in_md_queue), .in_md_id(in_md_id),
    .in_md_len(in_md_len), .in_gate_mask(in_gate_mask),
    .cfg_rate(cfg_rate), .cfg_bucket(cfg_bucket),
    .out_ready(out_ready), .in_tx_done(in_tx_done),
    .out_md_wr(out_md_wr), .out_md_queue(out_md_queue), .out_md_id(out_md_id),
    .out_md_len(out_md_len), .out_drop_wr(out_drop_wr), .out_drop_id(out_drop_id),
    .out_used_cnt(out_used_cnt), .out_mdin_cnt(out_mdin_cnt),
    .out_mdout_cnt(out_mdout_cnt), .out_drop_cnt(out_drop_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [CW-1:0] used(input int q);
    return out_used_cnt[q*CW +: CW];
  endfunction

  // Drives one metadata word for one cycle and returns in the following cycle.
  task automatic send(input int q, input logic [7:0] id, input logic [11:0] len);
    in_md_wr    = 1'b1;
    in_md_queue = 2'(q);
    in_md_id    = id;
    in_md_len   = len;
    tick();
    in_md_wr    = 1'b0;
  endtask

  task automatic tx_done();
    in_tx_done = 1'b1;
    tick();
    in_tx_done = 1'b0;
  endtask

  // Counts cycles until out_md_wr, bounded by max. A timeout counts as a failure.
  task automatic wait_issue(input string tag, input int max, output int n);
    n = 0;
    while (!out_md_wr && n < max) begin
      tick();
      n++;
    end
    check(tag, 64'(out_md_wr), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst_n = 1'b0; in_md_wr = 1'b0; in_md_queue = '0; in_md_id = '0; in_md_len = '0;
    in_gate_mask = 4'hF; cfg_rate = '0; cfg_bucket = '0; out_ready = 1'b1; in_tx_done = 1'b0;
    tick(); tick();
    check("rst_md_wr",   64'(out_md_wr),    64'd0);
    check("rst_drop_wr", 64'(out_drop_wr),  64'd0);
    check("rst_used",    64'(out_used_cnt), 64'd0);
    check("rst_mdin",    out_mdin_cnt,      64'd0);
    check("rst_mdout",   out_mdout_cnt,     64'd0);
    check("rst_dropcnt", 64'(out_drop_cnt), 64'd0);
    rst_n = 1'b1;
    tick();

    // 1: two-cycle latency, then no further issue until in_tx_done.
    send(2, 8'd5, 12'd64);                       // now cycle c+1
    check("t1_used_q2",  64'(used(2)),      64'd1);
    check("t1_wr_early", 64'(out_md_wr),    64'd0);
    tick();                                      // cycle c+2
    check("t1_wr",       64'(out_md_wr),    64'd1);
    check("t1_id",       64'(out_md_id),    64'd5);
    check("t1_queue",    64'(out_md_queue), 64'd2);
    check("t1_len",      64'(out_md_len),   64'd64);
    send(2, 8'd6, 12'd100);
    for (int i = 0; i < 5; i++) begin
      check("t1_hold", 64'(out_md_wr), 64'd0);
      tick();
    end
    check("t1_used_held", 64'(used(2)), 64'd1);
    tx_done();
    tick();
    check("t1_wr2", 64'(out_md_wr), 64'd1);
    check("t1_id2", 64'(out_md_id), 64'd6);
    tx_done();

    // 2: strict priority among entries queued during WAIT_DONE.
    send(1, 8'h09, 12'd10);
    tick();
    check("t2_first", 64'(out_md_id), 64'h09);
    send(3, 8'd1, 12'd20);
    send(0, 8'd2, 12'd30);
    check("t2_hold",    64'(out_md_wr), 64'd0);
    check("t2_used_q3", 64'(used(3)),   64'd1);
    check("t2_used_q0", 64'(used(0)),   64'd1);
    tx_done();
    tick();
    check("t2_id_hi",  64'(out_md_id),    64'd2);
    check("t2_q_hi",   64'(out_md_queue), 64'd0);
    tx_done();
    tick();
    check("t2_id_lo",  64'(out_md_id),    64'd1);
    check("t2_q_lo",   64'(out_md_queue), 64'd3);
    tx_done();
    check("t2_mdin",  out_mdin_cnt,  64'd5);
    check("t2_mdout", out_mdout_cnt, 64'd5);

    // 3: gate mask blocks queue 0 until its bit is set.
    in_gate_mask = 4'b1110;
    out_ready = 1'b0;
    send(0, 8'd3, 12'd40);
    send(1, 8'd4, 12'd50);
    out_ready = 1'b1;
    tick();
    check("t3_id_q1", 64'(out_md_id),    64'd4);
    check("t3_q_q1",  64'(out_md_queue), 64'd1);
    tx_done();
    tick(); tick();
    check("t3_gated",   64'(out_md_wr), 64'd0);
    check("t3_used_q0", 64'(used(0)),   64'd1);
    in_gate_mask = 4'hF;
    tick();
    check("t3_wr_q0", 64'(out_md_wr),    64'd1);
    check("t3_id_q0", 64'(out_md_id),    64'd3);
    tx_done();

    // 4: shaper on queue 3. Tokens are 0 in cycle r and k in cycle r+k, so a
    // 64-byte packet pops at the end of r+64 and issues in r+65.
    rst_n = 1'b0; cfg_rate = 16'd1; cfg_bucket = 16'd100;
    tick();
    rst_n = 1'b1;                                // cycle r
    send(3, 8'h33, 12'd64);                      // now r+1
    wait_issue("t4_issue", 200, n);
    check("t4_latency", 64'(n),         64'd64);
    check("t4_id",      64'(out_md_id), 64'h33);
    tx_done();
    repeat (200) tick();                         // bucket fills to its cap of 100
    send(3, 8'hA0, 12'd100);                     // sent in cycle s
    tick();                                      // s+2
    check("t4_full_bucket", 64'(out_md_id), 64'hA0);
    // After the pop, tokens = min(100+1-100,100) = 1, so tokens = k-1 in cycle s+k;
    // 50 tokens in s+51, issue in s+52, 48 ticks after s+4.
    tx_done();                                   // s+3
    send(3, 8'hB0, 12'd50);                      // s+4
    wait_issue("t4_issue2", 200, n);
    check("t4_cap_latency", 64'(n),         64'd48);
    check("t4_id2",         64'(out_md_id), 64'hB0);
    tx_done();

    // 5: overflow of queue 1, then a write to a full queue that pops in the same cycle.
    cfg_rate = '0;
    out_ready = 1'b0;
    for (int i = 0; i < 16; i++) send(1, 8'(8'h10 + i), 12'(i + 1));
    check("t5_used_full", 64'(used(1)),      64'd16);
    check("t5_no_drop",   64'(out_drop_wr),  64'd0);
    send(1, 8'h2A, 12'd77);
    check("t5_drop_wr",   64'(out_drop_wr),  64'd1);
    check("t5_drop_id",   64'(out_drop_id),  64'(EXP_DROP_ID));
    check("t5_used_q1",   64'(used(1)),      64'd16);
    check("t5_drop_cnt",  64'(out_drop_cnt), 64'd1);
    tick();
    check("t5_drop_pulse", 64'(out_drop_wr), 64'd0);
    out_ready = 1'b1;
    send(1, 8'h2B, 12'd78);
    check("t5_pop_wr",     64'(out_md_wr),    64'd1);
    check("t5_pop_id",     64'(out_md_id),    64'(EXP_HEAD_ID));
    check("t5_pop_nodrop", 64'(out_drop_wr),  64'd0);
    check("t5_pop_used",   64'(used(1)),      64'd16);
    check("t5_pop_cnt",    64'(out_drop_cnt), 64'd1);

    // 6: reset during WAIT_DONE with queued metadata.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t6_md_wr",   64'(out_md_wr),    64'd0);
    check("t6_md_id",   64'(out_md_id),    64'd0);
    check("t6_md_q",    64'(out_md_queue), 64'd0);
    check("t6_md_len",  64'(out_md_len),   64'd0);
    check("t6_drop_wr", 64'(out_drop_wr),  64'd0);
    check("t6_drop_id", 64'(out_drop_id),  64'd0);
    check("t6_used",    64'(out_used_cnt), 64'd0);
    check("t6_mdin",    out_mdin_cnt,      64'd0);
    check("t6_mdout",   out_mdout_cnt,     64'd0);
    check("t6_dropcnt", 64'(out_drop_cnt), 64'd0);
    tick(); tick();
    check("t6_quiet_wr",   64'(out_md_wr),   64'd0);
    check("t6_quiet_drop", 64'(out_drop_wr), 64'd0);
    send(0, 8'd7, 12'd20);
    tick();
    check("t6_idle_issue", 64'(out_md_wr), 64'd1);
    check("t6_idle_id",    64'(out_md_id), 64'd7);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
